// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for 7-segment capture and encoding.
//   - Segment codes for hex digits 0..F (bit0=a .. bit6=g, active high)
//   - Blank code
//   - Capture FSM state enum
//   - seg_encode(): hex value to segment pattern
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-segment pattern to hex decoder.
//   seg_i    [6:0] segment pattern (bit0=a .. bit6=g)
//   value_o  [3:0] decoded hex value (0 when not a legal digit)
//   legal_o        pattern is one of the 16 hex digit codes
//   blank_o        pattern is all segments off
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       legal_o,
    output logic       blank_o
);

    always_comb begin
        value_o = 4'h0;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:   value_o = 4'h0;
            SEG_1:   value_o = 4'h1;
            SEG_2:   value_o = 4'h2;
            SEG_3:   value_o = 4'h3;
            SEG_4:   value_o = 4'h4;
            SEG_5:   value_o = 4'h5;
            SEG_6:   value_o = 4'h6;
            SEG_7:   value_o = 4'h7;
            SEG_8:   value_o = 4'h8;
            SEG_9:   value_o = 4'h9;
            SEG_A:   value_o = 4'hA;
            SEG_B:   value_o = 4'hB;
            SEG_C:   value_o = 4'hC;
            SEG_D:   value_o = 4'hD;
            SEG_E:   value_o = 4'hE;
            SEG_F:   value_o = 4'hF;
            default: legal_o = 1'b0;
        endcase
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: debounced capture of an asynchronous 7-segment bus.
//   clk, rst_n          clock, async active-low reset
//   seg_in      [6:0]   raw segment lines (async to clk)
//   digit_out   [3:0]   last accepted hex value
//   digit_valid         pulse: legal digit accepted
//   pat_invalid         pulse: non-blank, non-digit pattern accepted
//   blank               level: last accepted pattern is all-off
//   seq_err             pulse: digit is not previous+1 (checker builds only)
//   err_count   [7:0]   saturating count of seq_err
// Optional: define SEG7_CAPTURE_SEQCHK_EN to build the sequence checker.
//
// state     | meaning
// ST_IDLE   | after reset, no candidate yet
// ST_SETTLE | counting consecutive samples equal to the candidate
// ST_HOLD   | pattern accepted, waiting for the sample to change
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       pat_invalid,
    output logic       blank,
    output logic       seq_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [6:0] sync1_q, sync2_q;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] cand_q, cand_d;
    logic [6:0] acc_q, acc_d;
    logic [3:0] digit_q, digit_d;
    logic       dv_q, dv_d;
    logic       pi_q, pi_d;
    logic       blank_q, blank_d;

    logic [3:0] dec_value;
    logic       dec_legal;
    logic       dec_blank;

    seg7_decode u_decode (
        .seg_i   (cand_q),
        .value_o (dec_value),
        .legal_o (dec_legal),
        .blank_o (dec_blank)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        acc_d   = acc_q;
        digit_d = digit_q;
        dv_d    = 1'b0;
        pi_d    = 1'b0;
        blank_d = blank_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (sync2_q != acc_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sync2_q;
                    cnt_d   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == STABLE_N) begin
                    // Enough matching samples already seen; accept regardless
                    // of the current sample, which just starts the next run.
                    acc_d = cand_q;
                    if (dec_blank) begin
                        blank_d = 1'b1;
                    end else if (dec_legal) begin
                        digit_d = dec_value;
                        dv_d    = 1'b1;
                        blank_d = 1'b0;
                    end else begin
                        pi_d    = 1'b1;
                        blank_d = 1'b0;
                    end
                    if (sync2_q != cand_q) begin
                        state_d = ST_SETTLE;
                        cand_d  = sync2_q;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (sync2_q == cand_q) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (sync2_q == acc_q) begin
                    state_d = ST_HOLD;
                end else begin
                    cand_d = sync2_q;
                    cnt_d  = 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 7'h00;
            sync2_q <= 7'h00;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= SEG_BLANK;
            acc_q   <= SEG_BLANK;
            digit_q <= 4'h0;
            dv_q    <= 1'b0;
            pi_q    <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            digit_q <= digit_d;
            dv_q    <= dv_d;
            pi_q    <= pi_d;
            blank_q <= blank_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = dv_q;
    assign pat_invalid = pi_q;
    assign blank       = blank_q;

`ifdef SEG7_CAPTURE_SEQCHK_EN
    logic       ref_vld_q;
    logic       seq_err_q;
    logic [7:0] err_cnt_q;
    logic [3:0] digit_exp;

    assign digit_exp = digit_q + 4'd1;

    // digit_q still holds the previous accepted digit while dv_d is high.
    // A blank or invalid acceptance breaks the chain; the next digit only
    // becomes the new reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_vld_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            seq_err_q <= 1'b0;
            if (dv_d) begin
                ref_vld_q <= 1'b1;
                if (ref_vld_q && (digit_d != digit_exp)) begin
                    seq_err_q <= 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
            end else if (pi_d || (blank_d && !blank_q)) begin
                ref_vld_q <= 1'b0;
            end
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_cnt_q;
`else
    assign seq_err   = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    localparam int N = 16;
`ifdef SEG7_CAPTURE_SEQCHK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       pat_invalid;
    logic       blank;
    logic       seq_err;
    logic [7:0] err_count;

    seg7_capture #(.STABLE_CYCLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .pat_invalid (pat_invalid),
        .blank       (blank),
        .seq_err     (seq_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cnt_dv = 0;
    int cnt_pi = 0;
    int cnt_se = 0;

    // Reference model: a pattern is accepted once the input has carried it
    // for exactly N consecutive clock edges (seen through a 2-edge
    // synchronizer) and it differs from the pattern currently accepted.
    logic [6:0] hist [$];
    logic [6:0] m_acc;
    int         m_digit;
    int         m_err;
    bit         m_blank, m_ref, m_dv, m_pi, m_se;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hexof(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N + 4; i++) hist.push_back(7'h00);
        m_acc = 7'h00; m_digit = 0; m_err = 0;
        m_blank = 1'b1; m_ref = 1'b0; m_dv = 1'b0; m_pi = 1'b0; m_se = 1'b0;
    endtask

    // hist[N+3] is the value on this edge; hist[1..N] are edges k-N-2..k-3.
    task automatic model_edge();
        logic [6:0] c;
        bit         run;
        int         h;
        hist.push_back(rst_n ? seg_in : 7'h00);
        void'(hist.pop_front());
        m_dv = 1'b0; m_pi = 1'b0; m_se = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        c = hist[N];
        run = (hist[0] != c) && (c != m_acc);
        for (int i = 1; i <= N; i++) if (hist[i] != c) run = 1'b0;
        if (run) begin
            m_acc = c;
            h = hexof(c);
            if (c == 7'h00) begin
                m_blank = 1'b1;
                m_ref = 1'b0;
            end else if (h < 0) begin
                m_pi = 1'b1;
                m_blank = 1'b0;
                m_ref = 1'b0;
            end else begin
                m_dv = 1'b1;
                m_blank = 1'b0;
                if (SEQ_EN && m_ref && (h != (m_digit + 1) % 16)) begin
                    m_se = 1'b1;
                    if (m_err < 255) m_err++;
                end
                m_digit = h;
                m_ref = 1'b1;
            end
        end
    endtask

    task automatic tick();
        int d;
        @(posedge clk);
        model_edge();
        #1;
        d = m_digit;
        chk("digit_out", 32'(digit_out), 32'(d[3:0]));
        chk("digit_valid", 32'(digit_valid), 32'(m_dv));
        chk("pat_invalid", 32'(pat_invalid), 32'(m_pi));
        chk("blank", 32'(blank), 32'(m_blank));
        chk("seq_err", 32'(seq_err), 32'(m_se));
        chk("err_count", 32'(err_count), 32'(m_err));
        cnt_dv += int'(digit_valid);
        cnt_pi += int'(pat_invalid);
        cnt_se += int'(seq_err);
    endtask

    task automatic hold(input logic [6:0] p, input int cycles);
        seg_in = p;
        repeat (cycles) tick();
    endtask

    task automatic clear_counts();
        cnt_dv = 0; cnt_pi = 0; cnt_se = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_digit_out", 32'(digit_out), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_pulses", 32'({digit_valid, pat_invalid, seq_err}), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Apply p and return the edge index (first sampling edge = 0) of the
    // first digit_valid; -1 if none within the window.
    task automatic measure(input logic [6:0] p, input string tag);
        int lat;
        lat = -1;
        seg_in = p;
        for (int i = 0; i < N + 20; i++) begin
            tick();
            if (digit_valid && lat < 0) lat = i;
        end
        chk(tag, 32'(lat), 32'(N + 2));
    endtask

    initial begin
        logic [6:0] p;
        int r;
        int len;

        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // steady 0x06 -> single digit_valid at cycle N+2
        clear_counts();
        measure(7'h06, "lat_06");
        chk("dv_once_06", 32'(cnt_dv), 32'h1);
        chk("digit_06", 32'(digit_out), 32'h1);
        chk("blank_06", 32'(blank), 32'h0);

        // 0x5B with a 5-cycle glitch to 0x4F
        hold(7'h5B, 6);
        hold(7'h4F, 5);
        clear_counts();
        measure(7'h5B, "lat_5b_glitch");
        chk("dv_once_5b", 32'(cnt_dv), 32'h1);
        chk("digit_5b", 32'(digit_out), 32'h2);

        // invalid 0x12
        clear_counts();
        hold(7'h12, N + 8);
        chk("pi_once_12", 32'(cnt_pi), 32'h1);
        chk("dv_none_12", 32'(cnt_dv), 32'h0);
        chk("digit_held_12", 32'(digit_out), 32'h2);

        // sequence E,F,0,2 then 300 bad steps
        apply_reset();
        clear_counts();
        hold(7'h79, N + 4);
        hold(7'h71, N + 4);
        hold(7'h3F, N + 4);
        hold(7'h5B, N + 4);
        chk("seq_err_pulses", 32'(cnt_se), SEQ_EN ? 32'h1 : 32'h0);
        chk("err_count_efo2", 32'(err_count), SEQ_EN ? 32'h1 : 32'h0);
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h06 : 7'h4F, N + 3);
        chk("err_count_sat", 32'(err_count), SEQ_EN ? 32'hFF : 32'h0);

        // reset at settle cycle 10 of 0x7F
        hold(7'h3F, N + 4);
        hold(7'h7F, 10);
        apply_reset();
        clear_counts();
        measure(7'h7F, "lat_after_rst");
        chk("dv_once_7f", 32'(cnt_dv), 32'h1);
        chk("digit_7f", 32'(digit_out), 32'h8);

        // blank after digit 5, then 5 again
        hold(7'h66, N + 4);
        hold(7'h6D, N + 4);
        clear_counts();
        hold(7'h00, N + 4);
        chk("blank_set", 32'(blank), 32'h1);
        chk("blank_digit_held", 32'(digit_out), 32'h5);
        chk("blank_no_pulse", 32'(cnt_dv + cnt_pi + cnt_se), 32'h0);
        clear_counts();
        hold(7'h6D, N + 6);
        chk("dv_after_blank", 32'(cnt_dv), 32'h1);
        chk("no_seq_err_after_blank", 32'(cnt_se), 32'h0);
        chk("blank_cleared", 32'(blank), 32'h0);

        // randomized patterns and hold lengths
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 99);
            if (r < 50) p = TBL[$urandom_range(0, 15)];
            else if (r < 65) p = 7'h00;
            else p = 7'($urandom_range(0, 127));
            len = $urandom_range(1, N + 8);
            if ($urandom_range(0, 99) == 0) apply_reset();
            hold(p, len);
        end
        hold(seg_in, N + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
